// File: rtl/de0_nano_pio_key_in.sv
// Avalon-MM input PIO: synchronizes board keys/switches, latches edges, raises a maskable irq.
// Optional per-bit debounce filter is compiled in with `define PIO_IN_DEBOUNCE_EN.
module de0_nano_pio_key_in #(
    parameter int unsigned DATA_WIDTH      = 4,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    localparam int unsigned ArmWidth = $clog2(SYNC_STAGES + 2);
    localparam logic [ArmWidth-1:0] ArmDone = ArmWidth'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_db;
    logic [DATA_WIDTH-1:0] d1_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [DATA_WIDTH-1:0] cap_q;
    logic [DATA_WIDTH-1:0] cap_d;
    logic [DATA_WIDTH-1:0] edge_sel;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] clear;
    logic [ArmWidth-1:0]   arm_q;
    logic [31:0]           rd_mux;
    logic                  armed;
    logic                  wr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign data_in = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int unsigned DbWidth = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [DbWidth-1:0]    db_cnt_q [DATA_WIDTH];
    logic [DATA_WIDTH-1:0] db_val_q;

    // A bit only follows data_in once it has disagreed for DEBOUNCE_CYCLES clocks in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_val_q <= '0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (data_in[i] != db_val_q[i]) begin
                    if (db_cnt_q[i] == DbWidth'(DEBOUNCE_CYCLES - 1)) begin
                        db_val_q[i] <= data_in[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + DbWidth'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign data_db = db_val_q;
`else
    assign data_db = data_in;
`endif

    assign armed = (arm_q == ArmDone);
    assign wr_en = chipselect && !write_n;
    assign clear = (wr_en && address == 2'd3) ? writedata[DATA_WIDTH-1:0] : '0;

    always_comb begin
        edge_sel = '0;
        if (EDGE_TYPE == 0) begin
            edge_sel = data_db & ~d1_q;
        end else if (EDGE_TYPE == 1) begin
            edge_sel = ~data_db & d1_q;
        end else begin
            edge_sel = data_db ^ d1_q;
        end
        edge_det = armed ? edge_sel : '0;
        // Set has priority over a coincident write-1-to-clear.
        cap_d    = (cap_q & ~clear) | edge_det;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[DATA_WIDTH-1:0] = data_db;
            2'd2:    rd_mux[DATA_WIDTH-1:0] = mask_q;
            2'd3:    rd_mux[DATA_WIDTH-1:0] = cap_q;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d1_q     <= '0;
            mask_q   <= '0;
            cap_q    <= '0;
            arm_q    <= '0;
            readdata <= '0;
        end else begin
            d1_q     <= data_db;
            cap_q    <= cap_d;
            readdata <= rd_mux;
            if (!armed) begin
                arm_q <= arm_q + ArmWidth'(1);
            end
            if (wr_en && address == 2'd2) begin
                mask_q <= writedata[DATA_WIDTH-1:0];
            end
        end
    end

    assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_de0_nano_pio_key_in.sv
// Directed bench for de0_nano_pio_key_in: rising/falling/any-edge instances on a shared bus.
// Debounce steps run only when built with PIO_IN_DEBOUNCE_EN (DEBOUNCE_CYCLES=8).
module tb_de0_nano_pio_key_in;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port, in_f, in_a;
    logic [31:0] readdata, rd_f, rd_a;
    logic        irq, irq_f, irq_a;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    de0_nano_pio_key_in #(
        .DATA_WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    de0_nano_pio_key_in #(
        .DATA_WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)
    ) dut_f (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_f),
        .in_port(in_f), .irq(irq_f)
    );

    de0_nano_pio_key_in #(
        .DATA_WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)
    ) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in_a), .irq(irq_a)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        in_f       = 4'hF;
        in_a       = 4'h0;

        // 1: reset with inputs held high
        tick();
        tick();
        check("reset_rd", readdata, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        reset = 1'b0;
        repeat (5) tick();
        check("t1_data", readdata, 32'h0000_000F);
        address = 2'd3;
        tick();
        check("t1_cap", readdata, 32'h0);
        check("t1_irq", {31'd0, irq}, 32'h0);

        // 2: 0 -> 5 rising edges
        in_port = 4'h0;
        repeat (5) tick();
        check("t2_no_fall", readdata, 32'h0);
        address = 2'd0;
        in_port = 4'h5;
        tick();
        tick();
        check("t2_data_lat", readdata, 32'h0);
        tick();
        check("t2_data", readdata, 32'h5);
        address = 2'd3;
        tick();
        check("t2_cap", readdata, 32'h5);
        check("t2_irq_masked", {31'd0, irq}, 32'h0);

        // 3: mask and clear
        bus_write(2'd2, 32'h4);
        check("t3_irq_on", {31'd0, irq}, 32'h1);
        bus_write(2'd3, 32'h4);
        check("t3_read_preclear", readdata, 32'h5);
        check("t3_irq_off", {31'd0, irq}, 32'h0);
        tick();
        check("t3_cap_after", readdata, 32'h1);

        // 4: set wins over a coincident clear
        in_port = 4'h7;
        repeat (4) tick();
        check("t4_cap_b1", readdata, 32'h3);
        in_port = 4'h5;
        repeat (4) tick();
        in_port = 4'h7;
        tick();
        tick();
        bus_write(2'd3, 32'h2);
        tick();
        check("t4_set_wins", readdata, 32'h3);
        bus_write(2'd3, 32'h2);
        tick();
        check("t4_clear", readdata, 32'h1);
        bus_write(2'd2, 32'h1);
        check("t4_irq_mask1", {31'd0, irq}, 32'h1);
        bus_write(2'd2, 32'h0);
        check("t4_irq_maskoff", {31'd0, irq}, 32'h0);

        // 5: falling-edge and any-edge instances
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        address = 2'd3;
        repeat (5) tick();
        check("t5_arm_no_spurious", readdata, 32'h0);
        in_f = 4'h0;
        repeat (4) tick();
        check("t5_fall_all", rd_f, 32'hF);
        in_a = 4'h1;
        repeat (4) tick();
        check("t5_any_rise", rd_a, 32'h1);
        bus_write(2'd3, 32'h1);
        tick();
        check("t5_any_cleared", rd_a, 32'h0);
        in_a = 4'h0;
        repeat (4) tick();
        check("t5_any_fall", rd_a, 32'h1);
        repeat (3) tick();
        check("t5_any_sticky", rd_a, 32'h1);

`ifdef PIO_IN_DEBOUNCE_EN
        // 6: debounce filter
        reset   = 1'b1;
        in_port = 4'h0;
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        bus_write(2'd2, 32'h1);
        address = 2'd0;
        in_port = 4'h1;
        repeat (5) tick();
        in_port = 4'h0;
        repeat (12) tick();
        check("t6_glitch_data", readdata, 32'h0);
        check("t6_glitch_irq", {31'd0, irq}, 32'h0);
        in_port = 4'h1;
        repeat (10) tick();
        check("t6_data_pre", readdata, 32'h0);
        check("t6_irq_pre", {31'd0, irq}, 32'h0);
        tick();
        check("t6_data", readdata, 32'h1);
        check("t6_irq", {31'd0, irq}, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
